pid_alu: RTL and testbench
==========================

# pid_alu

Shared arithmetic unit of the PID/balance controller datapath; module name `pid_alu`. The sequencer drives its operand selects and op flags each cycle. Two multiplexed operands feed either a scaled add/subtract or a signed fixed-point multiply, each with saturation. The result is registered into `dst` and written back to the controller's Accum/term registers.

## Interface
- No parameters; all widths fixed.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `Accum` in 16: accumulator operand.
- `Pcomp` in 16: P-compensation operand.
- `Icomp` in 12: I-compensation operand, signed.
- `Pterm` in 14: proportional gain, unsigned.
- `Iterm` in 12: integral gain, unsigned.
- `Fwd` in 12: forward term, unsigned.
- `A2D_res` in 12: ADC result, unsigned.
- `Error` in 12: error, signed.
- `Intgrl` in 12: integrator, signed.
- `src0sel` in 3: src0 operand select.
- `src1sel` in 3: src1 operand select.
- `multiply` in 1: select the multiply result.
- `sub` in 1: dst = src1 − src0.
- `mult2` in 1: src0 ×2.
- `mult4` in 1: src0 ×4.
- `saturate` in 1: saturate the add result to 12-bit signed.
- `dst` out 16: registered result.

## Operation
- src0 (16 b), by `src0sel`:
  - 000 A2D: {4'b0, A2D_res}
  - 001 Intgrl: sign-extended
  - 010 Icomp: sign-extended
  - 011 Pcomp: as is
  - 100 Pterm: {2'b0, Pterm}
  - 101–111: 0
- src1 (16 b), by `src1sel`:
  - 000 Accum
  - 001 Iterm: {4'b0, Iterm}
  - 010 Error: sign-extended
  - 011 ErrDiv2: {{8{Error[11]}}, Error[11:4]}
  - 100 Fwd: {4'b0, Fwd}
  - 101–111: 0
- Scaling: mult4 → src0<<2; else mult2 → src0<<1; else unchanged. mult4 wins if both are set. Bits shifted out are dropped.
- Add path: sum = src1 + (sub ? ~scaled : scaled) + sub, 16 b, carry discarded.
- Add saturation (only when saturate=1):
  - sum[15]=0 and sum>0x07FF → 0x07FF.
  - sum[15]=1 and sum<0xF800 → 0xF800.
  - Otherwise sum.
  - With saturate=0, raw 16-bit sum (wraps).
- Multiply path: signed src0[14:0] × signed src1[14:0] → 30-bit prod. Scaling, sub and saturate are ignored.
  - prod[29]=0 and prod[28:26]≠0 → 0x3FFF.
  - prod[29]=1 and prod[28:26]≠3'b111 → 0xC000.
  - Otherwise prod[27:12].
- next_dst = multiply ? mult_result : add_result.

## Timing
- Operand and sum/product logic is combinational. `dst` is a register updated every rising clk edge with next_dst. There is no enable.
- Latency 1 cycle: inputs valid before edge N appear on dst after edge N.
- rst_n low at an edge → dst = 0x0000; this overrides any op. The first edge with rst_n high loads next_dst normally.
- No handshake and no state machine. Select/flag changes take effect on the next edge. The combinational path must meet one clock period, including the 15×15 multiply.

## Structure
- Package `alu_pkg`: src0 select codes A2D2Src0..Pterm2Src0 (000–100) and src1 select codes Accum2Src1..Fwd2Src1 (000–100). The sequencer imports the same package.
- One sub-module `alu_mult_sat`: signed 15×15 multiply plus 14-bit saturate/extract, returning 16 b.
- Muxes, scaling, adder, add saturation and the dst register stay in `pid_alu`.

## Test plan
- Reset: rst_n=0 with any inputs → dst=0x0000 after the edge. Release → next op is loaded one cycle later.
- Selects, no flags (one result per cycle):
  - A2D 0x011 + Accum 0x0022 → 0x0033
  - Intgrl 0x022 + Iterm 0x022 → 0x0044
  - Icomp 0x022 + Error 0x033 → 0x0055
  - Pcomp 0x0033 + ErrDiv2 (Error 0x330) → 0x0066
  - Pterm 0x044 + Fwd 0x033 → 0x0077
  - Unused select codes 101–111 → operand reads as 0
- Scaling/sub with Pterm=0x011:
  - Fwd 0, mult2 → 0x0022; mult4 → 0x0044; mult2+mult4 → 0x0044
  - Fwd 0x022, sub → 0x0011
- Add saturation, Icomp 0, saturate=1:
  - Accum 0x7FFF → 0x07FF
  - Accum 0x8000 → 0xF800
  - Accum 0x0123 → 0x0123
  - saturate=0, Accum 0x7FFF → 0x7FFF
- Multiply:
  - Icomp 0x242 × Accum 0x0242 → 0x0051
  - Pcomp 0x7FFF × Accum 0x7FFF (both −1 in 15 b) → 0x0000
  - Pcomp 0xF000 × Accum 0x8000 → 0x0000
  - Pcomp 0x3FFF × Accum 0x3FFF → 0x3FFF (positive saturation)
  - Pcomp 0x3FFF × Accum 0x4001 → 0xC000 (negative saturation)
- Back-to-back op changes every cycle, including multiply toggling → each dst value matches the previous cycle's inputs exactly.

Source files
------------

// File: rtl/alu_pkg.sv
// Operand select encodings for the shared PID datapath ALU, plus saturation limits.
// The sequencer imports this same package so both sides agree on the codes.
package alu_pkg;

  localparam logic [2:0] A2D2Src0    = 3'b000;
  localparam logic [2:0] Intgrl2Src0 = 3'b001;
  localparam logic [2:0] Icomp2Src0  = 3'b010;
  localparam logic [2:0] Pcomp2Src0  = 3'b011;
  localparam logic [2:0] Pterm2Src0  = 3'b100;

  localparam logic [2:0] Accum2Src1   = 3'b000;
  localparam logic [2:0] Iterm2Src1   = 3'b001;
  localparam logic [2:0] Err2Src1     = 3'b010;
  localparam logic [2:0] ErrDiv22Src1 = 3'b011;
  localparam logic [2:0] Fwd2Src1     = 3'b100;

  // Add path clamps to the 12-bit signed range, multiply path to 15-bit signed.
  localparam logic [15:0] ADD_SAT_POS  = 16'h07FF;
  localparam logic [15:0] ADD_SAT_NEG  = 16'hF800;
  localparam logic [15:0] MULT_SAT_POS = 16'h3FFF;
  localparam logic [15:0] MULT_SAT_NEG = 16'hC000;

endpackage

// File: rtl/alu_mult_sat.sv
// Signed 15x15 fixed-point multiply; keeps product bits [27:12] and saturates
// to 0x3FFF / 0xC000 when the product does not fit that window.
module alu_mult_sat
  import alu_pkg::*;
(
  input  logic [14:0] i_a,
  input  logic [14:0] i_b,
  output logic [15:0] o_result
);

  logic signed [29:0] w_prod;

  assign w_prod = $signed(i_a) * $signed(i_b);

  always_comb begin
    o_result = w_prod[27:12];
    if (!w_prod[29] && (w_prod[28:26] != 3'b000)) begin
      o_result = MULT_SAT_POS;
    end else if (w_prod[29] && (w_prod[28:26] != 3'b111)) begin
      o_result = MULT_SAT_NEG;
    end
  end

endmodule

// File: rtl/pid_alu.sv
// Shared arithmetic unit of the PID/balance controller: operand muxes, scaled
// add/subtract with optional saturation, signed multiply, registered result.
module pid_alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Accum,
  input  logic [15:0] Pcomp,
  input  logic [11:0] Icomp,
  input  logic [13:0] Pterm,
  input  logic [11:0] Iterm,
  input  logic [11:0] Fwd,
  input  logic [11:0] A2D_res,
  input  logic [11:0] Error,
  input  logic [11:0] Intgrl,
  input  logic [2:0]  src0sel,
  input  logic [2:0]  src1sel,
  input  logic        multiply,
  input  logic        sub,
  input  logic        mult2,
  input  logic        mult4,
  input  logic        saturate,
  output logic [15:0] dst
);

  logic [15:0] w_src0;
  logic [15:0] w_src1;
  logic [15:0] w_scaled;
  logic [15:0] w_sum;
  logic [15:0] w_add_result;
  logic [15:0] w_mult_result;
  logic [15:0] w_next_dst;
  logic [15:0] r_dst;

  always_comb begin
    w_src0 = 16'h0000;
    case (src0sel)
      A2D2Src0:    w_src0 = {4'b0000, A2D_res};
      Intgrl2Src0: w_src0 = {{4{Intgrl[11]}}, Intgrl};
      Icomp2Src0:  w_src0 = {{4{Icomp[11]}}, Icomp};
      Pcomp2Src0:  w_src0 = Pcomp;
      Pterm2Src0:  w_src0 = {2'b00, Pterm};
      default:     w_src0 = 16'h0000;
    endcase
  end

  always_comb begin
    w_src1 = 16'h0000;
    case (src1sel)
      Accum2Src1:   w_src1 = Accum;
      Iterm2Src1:   w_src1 = {4'b0000, Iterm};
      Err2Src1:     w_src1 = {{4{Error[11]}}, Error};
      ErrDiv22Src1: w_src1 = {{8{Error[11]}}, Error[11:4]};
      Fwd2Src1:     w_src1 = {4'b0000, Fwd};
      default:      w_src1 = 16'h0000;
    endcase
  end

  // mult4 takes priority when both scale flags are set.
  assign w_scaled = mult4 ? {w_src0[13:0], 2'b00} :
                    mult2 ? {w_src0[14:0], 1'b0}  : w_src0;

  // Subtract as src1 + ~src0 + 1; carry out is discarded.
  assign w_sum = w_src1 + (sub ? ~w_scaled : w_scaled) + {15'd0, sub};

  always_comb begin
    w_add_result = w_sum;
    if (saturate) begin
      if (!w_sum[15] && (w_sum[14:11] != 4'h0)) begin
        w_add_result = ADD_SAT_POS;
      end else if (w_sum[15] && (w_sum[14:11] != 4'hF)) begin
        w_add_result = ADD_SAT_NEG;
      end
    end
  end

  alu_mult_sat u_mult_sat (
    .i_a      (w_src0[14:0]),
    .i_b      (w_src1[14:0]),
    .o_result (w_mult_result)
  );

  assign w_next_dst = multiply ? w_mult_result : w_add_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dst <= 16'h0000;
    end else begin
      r_dst <= w_next_dst;
    end
  end

  assign dst = r_dst;

endmodule

// File: tb/tb_pid_alu.sv
// Directed plus randomized back-to-back bench for pid_alu with an expected-value queue.
module tb_pid_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] Accum;
  logic [15:0] Pcomp;
  logic [11:0] Icomp;
  logic [13:0] Pterm;
  logic [11:0] Iterm;
  logic [11:0] Fwd;
  logic [11:0] A2D_res;
  logic [11:0] Error;
  logic [11:0] Intgrl;
  logic [2:0]  src0sel;
  logic [2:0]  src1sel;
  logic        multiply;
  logic        sub;
  logic        mult2;
  logic        mult4;
  logic        saturate;
  logic [15:0] dst;

  logic [15:0] exp_q[$];
  int          tests_run;
  int          tests_failed;

  pid_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Accum    (Accum),
    .Pcomp    (Pcomp),
    .Icomp    (Icomp),
    .Pterm    (Pterm),
    .Iterm    (Iterm),
    .Fwd      (Fwd),
    .A2D_res  (A2D_res),
    .Error    (Error),
    .Intgrl   (Intgrl),
    .src0sel  (src0sel),
    .src1sel  (src1sel),
    .multiply (multiply),
    .sub      (sub),
    .mult2    (mult2),
    .mult4    (mult4),
    .saturate (saturate),
    .dst      (dst)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written with integer arithmetic on the current inputs.
  function automatic logic [15:0] model();
    int     a;
    int     b;
    int     s;
    longint p;
    a = 0;
    b = 0;
    case (src0sel)
      3'd0: a = int'(A2D_res);
      3'd1: a = int'($signed(Intgrl));
      3'd2: a = int'($signed(Icomp));
      3'd3: a = int'($signed(Pcomp));
      3'd4: a = int'(Pterm);
      default: a = 0;
    endcase
    case (src1sel)
      3'd0: b = int'($signed(Accum));
      3'd1: b = int'(Iterm);
      3'd2: b = int'($signed(Error));
      3'd3: b = int'($signed(Error)) >>> 4;
      3'd4: b = int'(Fwd);
      default: b = 0;
    endcase
    if (multiply) begin
      a = a & 32'h7FFF;
      b = b & 32'h7FFF;
      if (a >= 16384) a = a - 32768;
      if (b >= 16384) b = b - 32768;
      p = longint'(a) * longint'(b);
      if (p >= 64'sd67108864) return 16'h3FFF;
      if (p < -64'sd67108864) return 16'hC000;
      return 16'((p >>> 12) & 64'hFFFF);
    end
    if (mult4) a = a * 4;
    else if (mult2) a = a * 2;
    s = sub ? (b - a) : (b + a);
    s = s & 32'hFFFF;
    if (s >= 32768) s = s - 65536;
    if (saturate) begin
      if (s > 2047) s = 2047;
      if (s < -2048) s = -2048;
    end
    return 16'(s);
  endfunction

  // Driver: set controls at the falling edge and queue the expected result.
  task automatic drive(input logic [2:0] s0, input logic [2:0] s1, input logic m,
                       input logic sb, input logic m2, input logic m4, input logic sat);
    @(negedge clk);
    src0sel  = s0;
    src1sel  = s1;
    multiply = m;
    sub      = sb;
    mult2    = m2;
    mult4    = m4;
    saturate = sat;
    #1;
    if (rst_n) exp_q.push_back(model());
    else       exp_q.push_back(16'h0000);
  endtask

  // Scoreboard: pop and compare just after the active edge.
  task automatic check(input string tag);
    logic [15:0] exp_v;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s: scoreboard queue empty, observed %h", tag, dst);
      return;
    end
    exp_v = exp_q.pop_front();
    tests_run++;
    assert (dst === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, dst, exp_v);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] s0, input logic [2:0] s1,
                      input logic m, input logic sb, input logic m2, input logic m4,
                      input logic sat);
    drive(s0, s1, m, sb, m2, m4, sat);
    check(tag);
  endtask

  // Directed checks against constants taken straight from hand calculation.
  task automatic step_k(input string tag, input logic [2:0] s0, input logic [2:0] s1,
                        input logic m, input logic sb, input logic m2, input logic m4,
                        input logic sat, input logic [15:0] k);
    drive(s0, s1, m, sb, m2, m4, sat);
    if (rst_n) begin
      void'(exp_q.pop_back());
      exp_q.push_back(k);
    end
    check(tag);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    Accum = 16'h1234; Pcomp = 16'h5678; Icomp = 12'h7FF; Pterm = 14'h1ABC;
    Iterm = 12'hFFF; Fwd = 12'h800; A2D_res = 12'hABC; Error = 12'h800; Intgrl = 12'h123;
    src0sel = 3'd3; src1sel = 3'd0; multiply = 1'b1; sub = 1'b1;
    mult2 = 1'b0; mult4 = 1'b0; saturate = 1'b1;

    step_k("reset_mult", 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step_k("reset_add",  3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    A2D_res = 12'h011; Accum = 16'h0022;
    step_k("release_a2d_accum", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0033);

    Intgrl = 12'h022; Iterm = 12'h022;
    step_k("intgrl_iterm", 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0044);
    Icomp = 12'h022; Error = 12'h033;
    step_k("icomp_error", 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0055);
    Pcomp = 16'h0033; Error = 12'h330;
    step_k("pcomp_errdiv2", 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0066);
    Pterm = 14'h044; Fwd = 12'h033;
    step_k("pterm_fwd", 3'd4, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0077);
    step_k("src0_unused_5", 3'd5, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0033);
    step_k("src0_unused_7", 3'd7, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0033);
    step_k("src1_unused_6", 3'd4, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0044);
    step_k("both_unused", 3'd6, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    Pterm = 14'h011; Fwd = 12'h000;
    step_k("mult2", 3'd4, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0022);
    step_k("mult4", 3'd4, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0044);
    step_k("mult2_mult4", 3'd4, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0044);
    Fwd = 12'h022;
    step_k("sub", 3'd4, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0011);

    Icomp = 12'h000; Accum = 16'h7FFF;
    step_k("sat_pos", 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h07FF);
    Accum = 16'h8000;
    step_k("sat_neg", 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hF800);
    Accum = 16'h0123;
    step_k("sat_in_range", 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0123);
    Accum = 16'h7FFF;
    step_k("no_sat_wrap", 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFF);

    Icomp = 12'h242; Accum = 16'h0242;
    step_k("mul_basic", 3'd2, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0051);
    Pcomp = 16'h7FFF; Accum = 16'h7FFF;
    step_k("mul_neg1_neg1", 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    Pcomp = 16'hF000; Accum = 16'h8000;
    step_k("mul_zero", 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    Pcomp = 16'h3FFF; Accum = 16'h3FFF;
    step_k("mul_sat_pos", 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3FFF);
    Accum = 16'h4001;
    step_k("mul_sat_neg", 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hC000);

    // Back-to-back random ops, one result every cycle, model-predicted.
    for (int i = 0; i < 60; i++) begin
      Accum   = 16'($urandom_range(0, 16'hFFFF));
      Pcomp   = 16'($urandom_range(0, 16'hFFFF));
      Icomp   = 12'($urandom_range(0, 12'hFFF));
      Pterm   = 14'($urandom_range(0, 14'h3FFF));
      Iterm   = 12'($urandom_range(0, 12'hFFF));
      Fwd     = 12'($urandom_range(0, 12'hFFF));
      A2D_res = 12'($urandom_range(0, 12'hFFF));
      Error   = 12'($urandom_range(0, 12'hFFF));
      Intgrl  = 12'($urandom_range(0, 12'hFFF));
      step("b2b_random", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'(i % 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in mid-stream overrides a pending op.
    @(negedge clk);
    rst_n = 1'b0;
    step_k("reset_midstream", 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
